// File: rtl/collision_checker.sv
// collision_checker
// Keeps the nearest first-row obstacle per lane from the per-frame obstacle
// stream. When the generator signals the end of the frame, it judges the
// player against the obstacle in the player's lane. It then emits a one-cycle
// result (collision, floor height) and keeps a sticky game_over flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   obstacle_valid      obstacle word valid this cycle
//   first_row           word belongs to the closest row
//   obstacle[15:0]      [15:13] type, [12:11] lane, [10:0] far-end depth
//   obstacles_done      one-cycle pulse, frame stream complete
//   player_lane/height/ducking  player state, latched on obstacles_done
//   restart             one-cycle pulse, clears game_over
//   result_valid        one-cycle pulse, result fields valid
//   collision           collision this frame (held until next result)
//   ground_height       floor height under player (held until next result)
//   game_over           sticky collision flag
//   busy                high while evaluating / reporting
//
// state    | meaning
// ---------+-----------------------------------------------
// COLLECT  | capture nearest first-row obstacle per lane
// EVAL     | judge latched player against selected slot
// REPORT   | result_valid high, slots cleared
module collision_checker #(
  parameter int PLAYER_DEPTH = 16,
  parameter int BARRIER_LEN  = 16,
  parameter int CAR_LEN      = 128,
  parameter int TRAIN_HEIGHT = 64,
  parameter int LOW_CLEAR    = 24,
  parameter int STEP_TOL     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        obstacle_valid,
  input  logic        first_row,
  input  logic [15:0] obstacle,
  input  logic        obstacles_done,
  input  logic [1:0]  player_lane,
  input  logic [7:0]  player_height,
  input  logic        player_ducking,
  input  logic        restart,
  output logic        result_valid,
  output logic        collision,
  output logic [7:0]  ground_height,
  output logic        game_over,
  output logic        busy
);

  typedef enum logic [1:0] {S_COLLECT, S_EVAL, S_REPORT} state_t;

  localparam logic [11:0] BAR_LIMIT = 12'(BARRIER_LEN + PLAYER_DEPTH);
  localparam logic [11:0] CAR_LIMIT = 12'(CAR_LEN + PLAYER_DEPTH);
  localparam logic [11:0] CAR_LEN_W = 12'(CAR_LEN);
  localparam logic [7:0]  ROOF_MIN  = 8'(TRAIN_HEIGHT - STEP_TOL);

  state_t      state;
  logic [2:0]  slot_type  [3];
  logic [10:0] slot_depth [3];
  logic [1:0]  lat_lane;
  logic [7:0]  lat_height;
  logic        lat_duck;

  logic [2:0]  sel_type;
  logic [10:0] sel_depth;
  logic [11:0] sel_depth_w;
  logic        overlap;
  logic        eval_coll;
  logic [7:0]  eval_ground;

  wire [2:0]  in_type  = obstacle[15:13];
  wire [1:0]  in_lane  = obstacle[12:11];
  wire [10:0] in_depth = obstacle[10:0];

  // Lane 3 matches no slot, so it sees an empty lane.
  always_comb begin
    sel_type  = 3'b000;
    sel_depth = 11'h7ff;
    for (int i = 0; i < 3; i++) begin
      if (lat_lane == 2'(i)) begin
        sel_type  = slot_type[i];
        sel_depth = slot_depth[i];
      end
    end
  end

  assign sel_depth_w = {1'b0, sel_depth};

  always_comb begin
    overlap     = 1'b0;
    eval_coll   = 1'b0;
    eval_ground = 8'd0;
    case (sel_type)
      3'b001, 3'b010, 3'b011: overlap = sel_depth_w < BAR_LIMIT;
      3'b100, 3'b101:         overlap = sel_depth_w < CAR_LIMIT;
      default:                overlap = 1'b0;
    endcase
    if (overlap) begin
      case (sel_type)
        3'b001: eval_coll = lat_height < 8'(LOW_CLEAR);
        3'b010: eval_coll = !lat_duck;
        3'b011: eval_coll = !lat_duck && (lat_height < 8'(LOW_CLEAR));
        3'b100: begin
          eval_coll   = lat_height < ROOF_MIN;
          eval_ground = 8'(TRAIN_HEIGHT);
        end
        3'b101: begin
          // Ramp rises toward the player: half the remaining car length.
          if (sel_depth_w < CAR_LEN_W)
            eval_ground = 8'((CAR_LEN_W - sel_depth_w) >> 1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_COLLECT;
      result_valid  <= 1'b0;
      collision     <= 1'b0;
      ground_height <= 8'd0;
      game_over     <= 1'b0;
      busy          <= 1'b0;
      lat_lane      <= 2'd0;
      lat_height    <= 8'd0;
      lat_duck      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        slot_type[i]  <= 3'b000;
        slot_depth[i] <= 11'h7ff;
      end
    end else begin
      // Set in REPORT outranks a same-cycle restart.
      if (state == S_REPORT && collision)
        game_over <= 1'b1;
      else if (restart)
        game_over <= 1'b0;

      case (state)
        S_COLLECT: begin
          result_valid <= 1'b0;
          if (obstacle_valid && first_row && in_type != 3'b000) begin
            for (int i = 0; i < 3; i++) begin
              if (in_lane == 2'(i) && in_depth < slot_depth[i]) begin
                slot_type[i]  <= in_type;
                slot_depth[i] <= in_depth;
              end
            end
          end
          if (obstacles_done) begin
            lat_lane   <= player_lane;
            lat_height <= player_height;
            lat_duck   <= player_ducking;
            busy       <= 1'b1;
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          result_valid  <= 1'b1;
          collision     <= eval_coll;
          ground_height <= eval_ground;
          state         <= S_REPORT;
        end
        S_REPORT: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            slot_type[i]  <= 3'b000;
            slot_depth[i] <= 11'h7ff;
          end
          state <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_checker.sv
module tb_collision_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obstacle_valid = 1'b0;
  logic        first_row = 1'b0;
  logic [15:0] obstacle = 16'd0;
  logic        obstacles_done = 1'b0;
  logic [1:0]  player_lane = 2'd0;
  logic [7:0]  player_height = 8'd0;
  logic        player_ducking = 1'b0;
  logic        restart = 1'b0;
  logic        result_valid;
  logic        collision;
  logic [7:0]  ground_height;
  logic        game_over;
  logic        busy;

  int total = 0;
  int bad   = 0;

  collision_checker dut (
    .clk(clk), .rst(rst),
    .obstacle_valid(obstacle_valid), .first_row(first_row), .obstacle(obstacle),
    .obstacles_done(obstacles_done),
    .player_lane(player_lane), .player_height(player_height),
    .player_ducking(player_ducking), .restart(restart),
    .result_valid(result_valid), .collision(collision),
    .ground_height(ground_height), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference judgement straight from the game rules, in plain integers.
  // Returns collision*256 + ground.
  function automatic int judge(input int t, input int d, input int h, input bit duck);
    int len;
    int c;
    int g;
    c = 0;
    g = 0;
    if (t < 1 || t > 5) return 0;
    len = (t <= 3) ? 16 : 128;
    if (d >= len + 16) return 0;
    case (t)
      1: c = (h < 24) ? 1 : 0;
      2: c = duck ? 0 : 1;
      3: c = (!duck && h < 24) ? 1 : 0;
      4: begin c = (h < 56) ? 1 : 0; g = 64; end
      default: g = (d >= 128) ? 0 : (128 - d) / 2;
    endcase
    return c * 256 + g;
  endfunction

  // Model: nearest obstacle per lane plus a frame timeline counted in edges.
  int m_type [3];
  int m_depth[3];
  int phase = 0;       // edges since the accepted done pulse, 0 = collecting
  int pend = 0;
  bit e_rv = 0, e_coll = 0, e_go = 0, e_busy = 0;
  int e_gnd = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_type[i] = 0; m_depth[i] = 2047; end
      phase = 0; e_rv = 0; e_coll = 0; e_gnd = 0; e_go = 0; e_busy = 0;
    end else begin
      if (phase == 2 && e_coll) e_go = 1;
      else if (restart) e_go = 0;
      if (phase == 0) begin
        e_rv = 0;
        if (obstacle_valid && first_row && obstacle[12:11] != 2'd3 && obstacle[15:13] != 3'd0
            && int'(obstacle[10:0]) < m_depth[obstacle[12:11]]) begin
          m_type[obstacle[12:11]]  = int'(obstacle[15:13]);
          m_depth[obstacle[12:11]] = int'(obstacle[10:0]);
        end
        if (obstacles_done) begin
          if (player_lane == 2'd3) pend = 0;
          else pend = judge(m_type[player_lane], m_depth[player_lane],
                            int'(player_height), player_ducking);
          phase = 1;
        end
      end else if (phase == 1) begin
        e_rv = 1; e_coll = pend[8]; e_gnd = pend % 256;
        phase = 2;
      end else begin
        e_rv = 0;
        for (int i = 0; i < 3; i++) begin m_type[i] = 0; m_depth[i] = 2047; end
        phase = 0;
      end
      e_busy = (phase != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("result_valid", int'(result_valid), int'(e_rv));
      chk("collision", int'(collision), int'(e_coll));
      chk("ground_height", int'(ground_height), e_gnd);
      chk("game_over", int'(game_over), int'(e_go));
      chk("busy", int'(busy), int'(e_busy));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int t, input int ln, input int d, input bit fr);
    obstacle = {3'(t), 2'(ln), 11'(d)};
    first_row = fr;
    obstacle_valid = 1'b1;
    step();
    obstacle_valid = 1'b0;
    first_row = 1'b0;
  endtask

  // Done pulse, then literal checks on the result cycle and the cycle after.
  task automatic frame(input string nm, input int ln, input int h, input bit duck,
                       input int ec, input int eg, input int ego);
    player_lane = 2'(ln);
    player_height = 8'(h);
    player_ducking = duck;
    obstacles_done = 1'b1;
    step();
    obstacles_done = 1'b0;
    obstacle_valid = 1'b0;
    first_row = 1'b0;
    step();
    chk({nm, "_rv"}, int'(result_valid), 1);
    chk({nm, "_coll"}, int'(collision), ec);
    chk({nm, "_gnd"}, int'(ground_height), eg);
    step();
    chk({nm, "_go"}, int'(game_over), ego);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk_en = 1;
    step();
    rst = 1'b0;
    chk("reset_rv", int'(result_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_go", int'(game_over), 0);

    frame("empty", 0, 0, 0, 0, 0, 0);

    send(1, 1, 10, 1);
    frame("low_hit", 1, 0, 0, 1, 0, 1);
    send(1, 1, 10, 1);
    frame("low_jump", 1, 30, 0, 0, 0, 1);

    send(2, 0, 5, 1);
    frame("high_duck", 0, 0, 1, 0, 0, 1);
    send(2, 0, 5, 1);
    frame("high_stand", 0, 0, 0, 1, 0, 1);
    do_restart();
    chk("restart_go", int'(game_over), 0);

    send(5, 2, 64, 1);
    frame("ramp64", 2, 0, 0, 0, 32, 0);
    send(5, 2, 200, 1);
    frame("ramp200", 2, 0, 0, 0, 0, 0);
    send(5, 2, 130, 1);
    frame("ramp130", 2, 0, 0, 0, 0, 0);

    send(4, 1, 100, 1);
    send(3, 1, 40, 1);
    frame("mid_keep", 1, 60, 0, 0, 0, 0);
    send(4, 1, 100, 1);
    frame("train", 1, 50, 0, 1, 64, 1);
    do_restart();
    send(4, 0, 143, 1);
    frame("train143", 0, 55, 0, 1, 64, 1);
    do_restart();
    send(4, 0, 143, 1);
    frame("train_roof", 0, 56, 0, 0, 64, 0);

    send(1, 2, 31, 1);
    frame("bar31", 2, 0, 0, 1, 0, 1);
    do_restart();
    send(1, 2, 32, 1);
    frame("bar32", 2, 0, 0, 0, 0, 0);

    // word and done in the same cycle
    obstacle = {3'd1, 2'd0, 11'd3};
    first_row = 1'b1;
    obstacle_valid = 1'b1;
    frame("same_cycle", 0, 0, 0, 1, 0, 1);
    do_restart();

    send(1, 0, 3, 0);
    frame("not_first", 0, 0, 0, 0, 0, 0);
    send(1, 3, 5, 1);
    frame("lane3", 3, 0, 0, 0, 0, 0);
    send(1, 0, 3, 1);
    frame("lane3_sel", 3, 0, 0, 0, 0, 0);

    // word arriving during EVAL is dropped
    obstacles_done = 1'b1;
    step();
    obstacles_done = 1'b0;
    send(2, 0, 1, 1);
    step();
    frame("drop_eval", 0, 0, 0, 0, 0, 0);

    // set beats a same-cycle restart
    send(1, 1, 10, 1);
    obstacles_done = 1'b1;
    player_lane = 2'd1;
    player_height = 8'd0;
    step();
    obstacles_done = 1'b0;
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("set_over_restart", int'(game_over), 1);

    // reset during EVAL
    send(1, 1, 10, 1);
    obstacles_done = 1'b1;
    step();
    obstacles_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_eval_rv", int'(result_valid), 0);
    chk("rst_eval_go", int'(game_over), 0);
    chk("rst_eval_busy", int'(busy), 0);
    step();
    chk("rst_eval_rv2", int'(result_valid), 0);
    frame("rst_cleared", 1, 0, 0, 0, 0, 0);

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_checker.md
Name: collision_checker

Overview:
- Consumes the per-frame obstacle stream from the obstacle generator and keeps the nearest first-row obstacle in each lane.
- When the generator's done pulse arrives, evaluates the player's lane, height and duck state against that lane's obstacle.
- Emits a one-cycle result: collision flag plus floor height under the player, for the player physics stage. Also keeps a sticky game_over flag.

Parameters:
- PLAYER_DEPTH, 16, depth extent of the player hitbox starting at depth 0.
- BARRIER_LEN, 16, depth length of barrier types 001/010/011.
- CAR_LEN, 128, depth length of train car (100) and ramp (101).
- TRAIN_HEIGHT, 64, height of train roof; top of ramp.
- LOW_CLEAR, 24, minimum player_height that clears low/middle barriers by jumping.
- STEP_TOL, 8, player_height >= TRAIN_HEIGHT-STEP_TOL counts as on the roof.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- obstacle_valid  in  1  obstacle word valid this cycle
- first_row  in  1  obstacle belongs to the closest row
- obstacle  in  16  [15:13] type, [12:11] lane, [10:0] depth (unsigned, far END of obstacle)
- obstacles_done  in  1  one-cycle pulse: frame stream complete
- player_lane  in  2  current lane 0..2
- player_height  in  8  player feet height, unsigned
- player_ducking  in  1  player is ducking
- restart  in  1  one-cycle pulse, clears game_over
- result_valid  out  1  one-cycle pulse, result fields valid
- collision  out  1  collision this frame
- ground_height  out  8  floor height under player this frame
- game_over  out  1  sticky collision flag
- busy  out  1  high in EVAL and REPORT states

Behaviour:
- Reset: state COLLECT. All three lane slots cleared (type 000, depth 7FF). result_valid=0, collision=0, ground_height=0, game_over=0, busy=0.
- Reset wins over every other input, including mid-EVAL.
- COLLECT: on obstacle_valid && first_row && lane<=2 && type!=000, write {type,depth} to slot[lane] if depth < slot depth (strictly). Lane 3 and non-first_row words are ignored.
- Valid and done in the same cycle: the word is captured before evaluation.
- obstacles_done in COLLECT:
  - latch player_lane, player_height, player_ducking;
  - go to EVAL.
- EVAL (1 cycle): select slot[latched lane]; lane 3 selects an empty slot. Overlap when depth < len+PLAYER_DEPTH, where len is BARRIER_LEN or CAR_LEN by type. Compute in 12-bit arithmetic with no wrap. No overlap or type 000: collision=0, ground=0. Otherwise:
  - 001 (low): collision iff height < LOW_CLEAR; ground 0.
  - 010 (high): collision iff !ducking; ground 0.
  - 011 (middle): collision iff !ducking && height < LOW_CLEAR; ground 0.
  - 100 (train): collision iff height < TRAIN_HEIGHT-STEP_TOL; ground TRAIN_HEIGHT.
  - 101 (ramp): never collides. Ground = 0 if depth >= CAR_LEN, else (CAR_LEN-depth)>>1, truncated.
  - 110/111: treated as empty.
- REPORT (1 cycle):
  - result_valid=1 with collision and ground_height registered; these hold until the next REPORT.
  - All slots cleared.
  - Return to COLLECT.
- Latency: done at cycle T, result_valid at T+2.
- In EVAL/REPORT, obstacle_valid and obstacles_done are ignored (dropped).
- game_over: set in REPORT when collision=1; cleared by restart. Set has priority over a same-cycle restart. It does not gate collection.

Test Plan:
- Reset, then done with no obstacles -> result_valid at T+2, collision=0, ground_height=0, game_over=0.
- Lane 1: type 001, depth 10; player lane 1, height 0 -> collision=1, game_over=1. Repeat with height 30 -> collision=0.
- Lane 0: type 010, depth 5. Ducking=1 -> collision=0; ducking=0 -> collision=1. restart -> game_over=0.
- Lane 2 ramp at depth 64, player height 0 -> collision=0, ground_height=32. Depth 200 -> ground 0, collision=0 (no overlap, 200 >= 144).
- Lane 1: train depth 100, and first_row barrier depth 40 in the same lane, height 60 -> slot keeps barrier (40<100); type 011 not ducking, 60 >= 24 -> collision=0, ground 0. Train alone at height 50 -> collision=1, ground 64.
- Assert rst during EVAL -> next cycle outputs 0, slots cleared, no result_valid. A non-first_row or lane-3 word is never captured.
